muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, as the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, as the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, as the reset; reset is synchronous and active-low.
REQ-004 SHALL have port start, input, 1, as the operation request, sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1, to cancel any operation in progress.
REQ-006 SHALL have port funct3, input, 3, as the op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports operand_a and operand_b, input, WIDTH, as rs1 and rs2 (a = dividend/multiplicand).
REQ-008 SHALL have port busy, output, 1, high while an accepted operation is outstanding.
REQ-009 SHALL have port done, output, 1, as a one-cycle completion pulse.
REQ-010 SHALL have port result, output, WIDTH, feeding one input of the writeback result select mux.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-012 IDLE: start=1 and abort=0 at an edge -> latch funct3, operands and sign flags; load iteration counter to WIDTH-1; go to CALC.
REQ-013 CALC: one radix-2 step per cycle (shift-add multiply on operand magnitudes; restoring divide); exit to DONE after the step with counter==0, i.e. exactly WIDTH steps.
REQ-014 DONE: lasts one cycle; done=1, result valid; next state IDLE.
REQ-015 Fixed latency for all ops and operand values: done is high in the cycle after the (WIDTH+1)th edge following the start-sampling edge (33 edges for WIDTH=32).
REQ-016 busy SHALL be high in CALC and DONE and low in IDLE; combinationally derived from state.
REQ-017 Multiply: 2*WIDTH-bit product; MUL returns low half; MULH/MULHSU/MULHU return high half with signed*signed, signed*unsigned and unsigned*unsigned interpretation. Signed magnitudes SHALL be negated back using two's complement across 2*WIDTH bits.
REQ-018 Divide: DIV/REM signed (quotient truncates toward zero, remainder takes dividend's sign); DIVU/REMU unsigned.
REQ-019 Divisor 0: quotient all-ones, remainder = operand_a, for signed and unsigned ops; latency unchanged.
REQ-020 Signed overflow (a = most-negative, b = -1): DIV returns most-negative, REM returns 0; latency unchanged.
REQ-021 result SHALL be registered, updated only on the edge entering DONE, and held until the next DONE.
REQ-022 start while busy SHALL be ignored; no queueing.
REQ-023 abort=1 in CALC or DONE -> IDLE at the next edge; done suppressed from that cycle on; result unchanged.
REQ-024 abort=1 and start=1 together in IDLE -> start ignored.
REQ-025 Operand and funct3 changes after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-026 rst_n=0 at an edge -> state IDLE, busy=0, done=0, result=0, counter and datapath registers cleared; takes priority over start and abort.
REQ-027 Reset during CALC or DONE SHALL abandon the operation with no done pulse afterwards.

Structure
REQ-028 Shared package muldiv_pkg SHALL hold the funct3 encodings and the FSM state typedef.
REQ-029 The iterative quotient/remainder step SHALL be one sub-module, div_step; sign handling, multiplier and FSM stay in muldiv_unit.

Verification
REQ-030 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done high only in the cycle after the 33rd edge.
REQ-031 a=b=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
REQ-032 a=0xFFFFFFF9, b=2: DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU -> 0x7FFFFFFC.
REQ-033 a=5, b=0: DIVU -> 0xFFFFFFFF, REMU -> 5; a=0x80000000, b=0xFFFFFFFF: DIV -> 0x80000000, REM -> 0. All four take the same 33 edges.
REQ-034 Start DIV, pulse start with new operands at edge 5 -> ignored, original result delivered. Start again, abort at edge 10 -> busy=0 next cycle, no done.
REQ-035 Start MUL, drive rst_n=0 at edge 20 -> busy=0, done=0, result=0 after that edge; no done follows.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative multiply/divide unit.
//   - funct3 operation encodings (RISC-V M extension ordering)
//   - FSM state type used by muldiv_unit
//   - small decode helper shared by the datapath
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // All divide/remainder encodings have funct3[2] set.
    function automatic logic op_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// div_step: one restoring-division iteration on unsigned magnitudes.
// Ports:
//   rem      - partial remainder entering this step
//   quo      - dividend bits still to be shifted in (MSB first), with
//              quotient bits collected at the LSB end
//   divisor  - unsigned divisor magnitude
//   rem_next - partial remainder after the trial subtraction
//   quo_next - quo shifted left by one with the new quotient bit inserted
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    // Trial subtraction; the remainder stays below the divisor, so the
    // shifted value fits in WIDTH+1 bits and any difference fits in WIDTH.
    always_comb begin
        shifted_s = {rem, quo[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, divisor};
        if (shifted_s >= {1'b0, divisor}) begin
            rem_next = diff_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: fixed-latency radix-2 multiply/divide unit (RV32M funct3).
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   start      - operation request, honoured only in IDLE and without abort
//   abort      - cancels the operation in flight, result left untouched
//   funct3     - operation select (see muldiv_pkg)
//   operand_a  - rs1 (multiplicand / dividend)
//   operand_b  - rs2 (multiplier / divisor)
//   busy       - high in CALC and DONE
//   done       - one-cycle completion pulse, result valid alongside
//   result     - registered result, held until the next completion
// Both datapaths work on magnitudes and fix the sign up on the edge that
// enters DONE, so every op takes exactly WIDTH CALC cycles.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       op_r;
    logic             neg_res_r;
    logic             div_zero_r;
    logic [WIDTH-1:0] a_raw_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] result_r;
    logic             done_r;

    logic               sign_a_s;
    logic               sign_b_s;
    logic               neg_res_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH-1:0]   div_rem_s;
    logic [WIDTH-1:0]   div_quo_s;
    logic [WIDTH-1:0]   step_acc_s;
    logic [WIDTH-1:0]   step_lo_s;
    logic [2*WIDTH-1:0] product_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;
    logic [WIDTH-1:0]   final_s;

    // Operand sign flags and magnitudes for the request being offered.
    always_comb begin
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
        case (funct3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                sign_a_s = operand_a[WIDTH-1];
                sign_b_s = operand_b[WIDTH-1];
            end
            F3_MULHSU: begin
                sign_a_s = operand_a[WIDTH-1];
                sign_b_s = 1'b0;
            end
            default: begin
                sign_a_s = 1'b0;
                sign_b_s = 1'b0;
            end
        endcase
        if (sign_a_s) begin
            mag_a_s = -operand_a;
        end else begin
            mag_a_s = operand_a;
        end
        if (sign_b_s) begin
            mag_b_s = -operand_b;
        end else begin
            mag_b_s = operand_b;
        end
        // Remainder follows the dividend; quotient and product follow a^b.
        if (funct3 == F3_REM) begin
            neg_res_s = sign_a_s;
        end else begin
            neg_res_s = sign_a_s ^ sign_b_s;
        end
    end

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (acc_r),
        .quo      (lo_r),
        .divisor  (opb_r),
        .rem_next (div_rem_s),
        .quo_next (div_quo_s)
    );

    // Next iteration: shift-add multiply ({acc,lo} shifts right, lo holds
    // the multiplier) or one restoring divide step (acc=rem, lo=quotient).
    always_comb begin
        if (lo_r[0]) begin
            mul_sum_s = {1'b0, acc_r} + {1'b0, opb_r};
        end else begin
            mul_sum_s = {1'b0, acc_r};
        end
        if (op_is_div(op_r)) begin
            step_acc_s = div_rem_s;
            step_lo_s  = div_quo_s;
        end else begin
            step_acc_s = mul_sum_s[WIDTH:1];
            step_lo_s  = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end
    end

    // Sign fix-up and selection of the value captured when entering DONE.
    always_comb begin
        if (neg_res_r) begin
            product_s = -{step_acc_s, step_lo_s};
            quo_fix_s = -step_lo_s;
            rem_fix_s = -step_acc_s;
        end else begin
            product_s = {step_acc_s, step_lo_s};
            quo_fix_s = step_lo_s;
            rem_fix_s = step_acc_s;
        end
        case (op_r)
            F3_MUL:                        final_s = product_s[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  final_s = product_s[2*WIDTH-1:WIDTH];
            F3_DIV, F3_DIVU: begin
                if (div_zero_r) begin
                    final_s = {WIDTH{1'b1}};
                end else begin
                    final_s = quo_fix_s;
                end
            end
            F3_REM, F3_REMU: begin
                if (div_zero_r) begin
                    final_s = a_raw_r;
                end else begin
                    final_s = rem_fix_s;
                end
            end
            default:                       final_s = {WIDTH{1'b0}};
        endcase
    end

    // Control FSM together with the iteration registers it sequences.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            op_r       <= 3'b000;
            neg_res_r  <= 1'b0;
            div_zero_r <= 1'b0;
            a_raw_r    <= {WIDTH{1'b0}};
            opb_r      <= {WIDTH{1'b0}};
            acc_r      <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            result_r   <= {WIDTH{1'b0}};
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start && !abort) begin
                        op_r       <= funct3;
                        neg_res_r  <= neg_res_s;
                        div_zero_r <= (operand_b == {WIDTH{1'b0}});
                        a_raw_r    <= operand_a;
                        opb_r      <= mag_b_s;
                        acc_r      <= {WIDTH{1'b0}};
                        lo_r       <= mag_a_s;
                        cnt_r      <= CNT_LOAD;
                        state_r    <= ST_CALC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (abort) begin
                        done_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        acc_r <= step_acc_s;
                        lo_r  <= step_lo_s;
                        cnt_r <= cnt_r - CNT_ONE;
                        if (cnt_r == {CNT_W{1'b0}}) begin
                            result_r <= final_s;
                            done_r   <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            done_r  <= 1'b0;
                            state_r <= ST_CALC;
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_r != ST_IDLE);
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized self-checking bench for muldiv_unit.
// Edges are counted with the start-sampling edge as edge 1; done must be
// high only after edge 33 (WIDTH+1 edges in total) for every operation.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic from the RV32M rules.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f3)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Full operation with latency check; inputs are scrambled after acceptance.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        funct3 = f3; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        funct3 = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
        check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        for (int e = 2; e <= 34; e++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_done"}, {31'd0, done}, {31'd0, (e == 33)});
            if (e == 33) check({tag, "_result"}, result, exp);
        end
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_held"}, result, exp);
    endtask

    initial begin
        logic [31:0] ra, rb, rexp, prev;
        logic [2:0]  rf;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        funct3 = 3'b000; operand_a = 32'd0; operand_b = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        rst_n = 1'b1;

        // start together with abort in IDLE is ignored
        start = 1'b1; abort = 1'b1; funct3 = 3'b100; operand_a = 32'd9; operand_b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", {31'd0, busy}, 32'd0);

        run_op("mul_neg",   3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulhu_m1",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulh_m1",   3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_neg",   3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run_op("rem_neg",   3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run_op("divu_big",  3'b101, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC);
        run_op("divu_zero", 3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF);
        run_op("remu_zero", 3'b111, 32'd5,          32'd0,         32'd5);
        run_op("div_ovf",   3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",   3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
        run_op("div_zero",  3'b100, 32'hFFFF_FF00,  32'd0,         32'hFFFF_FFFF);
        run_op("rem_zero",  3'b110, 32'hFFFF_FF00,  32'd0,         32'hFFFF_FF00);

        // randomized ops, biased toward corner operands
        for (int i = 0; i < 24; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = -32'($urandom_range(1, 15));
                default: ;
            endcase
            rexp = ref_model(rf, ra, rb);
            run_op("rand", rf, ra, rb, rexp);
        end

        // start pulsed while busy is ignored
        @(negedge clk);
        funct3 = 3'b100; operand_a = 32'd100; operand_b = 32'hFFFF_FFF9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int e = 2; e <= 34; e++) begin
            if (e == 5) begin
                start = 1'b1; funct3 = 3'b000; operand_a = 32'd3; operand_b = 32'd4;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            check("busy_start_done", {31'd0, done}, {31'd0, (e == 33)});
            if (e == 33) check("busy_start_result", result, ref_model(3'b100, 32'd100, 32'hFFFF_FFF9));
        end
        start = 1'b0;
        check("busy_start_idle", {31'd0, busy}, 32'd0);
        prev = result;

        // abort sampled at edge 10
        funct3 = 3'b101; operand_a = 32'd1000; operand_b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int e = 2; e <= 10; e++) begin
            abort = (e == 10);
            @(posedge clk);
            @(negedge clk);
        end
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        check("abort_result_kept", result, prev);

        // reset sampled at edge 20 during a MUL
        funct3 = 3'b000; operand_a = 32'd12345; operand_b = 32'd678; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int e = 2; e <= 20; e++) begin
            rst_n = (e != 20);
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_no_done", {31'd0, done}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
